// File: rtl/tlc_param_fsm.sv
// tlc_param_fsm: two-road (A/B) traffic-light controller with parameterised
// phase durations, timed (auto) or button-held (manual) green phases, lamp
// decode and per-road seconds-remaining outputs for the 7-segment path.
// Optional build macro: TLC_ALL_RED_EN inserts the RA/RB all-red clearance
// phases (RED_T ticks each); without it yellow hands over directly to the
// other road's green.
module tlc_param_fsm #(
    parameter int CNT_W   = 6,
    parameter int GRN_A_T = 20,
    parameter int GRN_B_T = 15,
    parameter int YEL_T   = 3,
    parameter int RED_T   = 2
) (
    input  logic             clk_f,
    input  logic             rst_i,
    input  logic             tick_i,
    input  logic             mode_i,
    input  logic             button_i,
    output logic             l_red_A,
    output logic             l_yellow_A,
    output logic             l_green_A,
    output logic             l_red_B,
    output logic             l_yellow_B,
    output logic             l_green_B,
    output logic [CNT_W-1:0] l_7_A,
    output logic [CNT_W-1:0] l_7_B,
    output logic [2:0]       phase_o
);

    typedef enum logic [2:0] {
        AG = 3'd0, AY = 3'd1, RA = 3'd2, BG = 3'd3, BY = 3'd4, RB = 3'd5
    } state_t;

    localparam int SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] SAT_MAX = {2'b00, {CNT_W{1'b1}}};

    // Clearance time that a red road still has to wait through before its green
`ifdef TLC_ALL_RED_EN
    localparam int CLR_T = RED_T;
`else
    localparam int CLR_T = 0;
`endif

    // The register holds a raw 3-bit code so illegal codes 6/7 are representable
    // and can be recovered from.
    logic [2:0]       state_reg;
    state_t           state_next;
    state_t           succ;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             hold;
    logic             release_btn;
    logic [SUM_W-1:0] cnt_ext;
    logic [SUM_W-1:0] sum_a;
    logic [SUM_W-1:0] sum_b;

    function automatic logic [CNT_W-1:0] phase_len(input state_t s);
        case (s)
            AG:      phase_len = CNT_W'(GRN_A_T);
            BG:      phase_len = CNT_W'(GRN_B_T);
            AY, BY:  phase_len = CNT_W'(YEL_T);
            default: phase_len = CNT_W'(RED_T);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat(input logic [SUM_W-1:0] v);
        sat = (v > SAT_MAX) ? SAT_MAX[CNT_W-1:0] : v[CNT_W-1:0];
    endfunction

    assign hold    = mode_i && ((state_reg == AG) || (state_reg == BG));
    assign cnt_ext = {2'b00, cnt_reg};

    // State and counter register; reset wins over any tick or button
    always_ff @(posedge clk_f) begin
        if (rst_i) begin
            state_reg <= AG;
            cnt_reg   <= CNT_W'(GRN_A_T);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state and counter: manual hold on greens, otherwise tick countdown
    always_comb begin
        state_next  = AG;
        cnt_next    = cnt_reg;
        succ        = AG;
        release_btn = 1'b0;
        case (state_reg)
            AG: begin
                state_next  = AG;
                succ        = AY;
                release_btn = button_i;
            end
`ifdef TLC_ALL_RED_EN
            AY: begin state_next = AY; succ = RA; end
            BY: begin state_next = BY; succ = RB; end
`else
            AY: begin state_next = AY; succ = BG; end
            BY: begin state_next = BY; succ = AG; end
`endif
            RA: begin state_next = RA; succ = BG; end
            BG: begin
                state_next  = BG;
                succ        = BY;
                release_btn = !button_i;
            end
            RB: begin state_next = RB; succ = AG; end
            default: begin
                // Illegal code: fall back to a fresh A green
                state_next = AG;
                succ       = AG;
            end
        endcase

        if (state_reg > 3'd5) begin
            cnt_next = phase_len(AG);
        end else if (hold) begin
            if (release_btn) begin
                state_next = succ;
                cnt_next   = phase_len(succ);
            end else begin
                cnt_next = phase_len(state_next);
            end
        end else if (tick_i) begin
            if (cnt_reg <= CNT_W'(1)) begin
                state_next = succ;
                cnt_next   = phase_len(succ);
            end else begin
                cnt_next = cnt_reg - CNT_W'(1);
            end
        end
    end

    // Lamp decode from the registered state; illegal codes show red both ways
    always_comb begin
        l_red_A    = 1'b1;
        l_yellow_A = 1'b0;
        l_green_A  = 1'b0;
        l_red_B    = 1'b1;
        l_yellow_B = 1'b0;
        l_green_B  = 1'b0;
        case (state_reg)
            AG:      begin l_red_A = 1'b0; l_green_A  = 1'b1; end
            AY:      begin l_red_A = 1'b0; l_yellow_A = 1'b1; end
            BG:      begin l_red_B = 1'b0; l_green_B  = 1'b1; end
            BY:      begin l_red_B = 1'b0; l_yellow_B = 1'b1; end
            default: ;
        endcase
    end

    // Display: own count when moving, count plus waiting phases when red
    always_comb begin
        sum_a = cnt_ext;
        sum_b = cnt_ext;
        case (state_reg)
            AG: sum_b = cnt_ext + SUM_W'(YEL_T) + SUM_W'(CLR_T);
            AY: sum_b = cnt_ext + SUM_W'(CLR_T);
            BG: sum_a = cnt_ext + SUM_W'(YEL_T) + SUM_W'(CLR_T);
            BY: sum_a = cnt_ext + SUM_W'(CLR_T);
            default: ;
        endcase
        if (hold) begin
            l_7_A = '1;
            l_7_B = '1;
        end else begin
            l_7_A = sat(sum_a);
            l_7_B = sat(sum_b);
        end
    end

    assign phase_o = state_reg;

endmodule
